// File: rtl/cluster_pwr_seq_pkg.sv
// Shared types for the cluster power sequencer: state encoding, default delays, output vector presets.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package cluster_pwr_seq_pkg;

    localparam int DEF_ACK_TIMEOUT = 1024;
    localparam int DEF_ISO_CYCLES  = 4;
    localparam int DEF_RST_CYCLES  = 8;
    localparam int DEF_CNT_WIDTH   = 16;

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_PWR_UP = 3'd1,
        ST_ISO    = 3'd2,
        ST_RST    = 3'd3,
        ST_ON     = 3'd4,
        ST_DRAIN  = 3'd5,
        ST_PWR_DN = 3'd6,
        ST_ERR    = 3'd7
    } state_t;

    typedef struct packed {
        logic pow;
        logic byp;
        logic rstn;
        logic fetch;
    } pwr_out_t;

    localparam pwr_out_t OUT_OFF = '{pow: 1'b0, byp: 1'b1, rstn: 1'b0, fetch: 1'b0};
    localparam pwr_out_t OUT_ERR = '{pow: 1'b0, byp: 1'b1, rstn: 1'b0, fetch: 1'b0};

    // ERR keeps whatever the power switch was doing when the fault hit.
    function automatic pwr_out_t state_outputs(state_t s, logic pow_hold);
        pwr_out_t o;
        o = OUT_OFF;
        case (s)
            ST_OFF:    o = OUT_OFF;
            ST_PWR_UP: o = '{pow: 1'b1, byp: 1'b1, rstn: 1'b0, fetch: 1'b0};
            ST_ISO:    o = '{pow: 1'b1, byp: 1'b0, rstn: 1'b0, fetch: 1'b0};
            ST_RST:    o = '{pow: 1'b1, byp: 1'b0, rstn: 1'b1, fetch: 1'b0};
            ST_ON:     o = '{pow: 1'b1, byp: 1'b0, rstn: 1'b1, fetch: 1'b1};
            ST_DRAIN:  o = '{pow: 1'b1, byp: 1'b0, rstn: 1'b1, fetch: 1'b0};
            ST_PWR_DN: o = OUT_OFF;
            ST_ERR: begin
                o     = OUT_ERR;
                o.pow = pow_hold;
            end
            default:   o = OUT_OFF;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/cluster_pwr_seq_if.sv
// Command and cluster-control bundle between the SoC register file, the sequencer and the cluster.
// Latency: n/a (wires only); irq_o exists only with CLUSTER_PWR_SEQ_IRQ_EN.
// Backpressure: cmd_valid_i/cmd_ready_o handshake; the sequencer side never stalls the cluster side.
interface cluster_pwr_seq_if;
    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic       cmd_on_i;
    logic       pwr_ack_i;
    logic       cluster_busy_i;
    logic       cluster_pow_o;
    logic       cluster_byp_o;
    logic       cluster_rstn_o;
    logic       cluster_fetch_enable_o;
    logic       done_o;
    logic       err_o;
    logic [2:0] state_o;
`ifdef CLUSTER_PWR_SEQ_IRQ_EN
    logic       irq_o;

    modport master (
        output cmd_valid_i, cmd_on_i, pwr_ack_i, cluster_busy_i,
        input  cmd_ready_o, cluster_pow_o, cluster_byp_o, cluster_rstn_o,
               cluster_fetch_enable_o, done_o, err_o, state_o, irq_o
    );
    modport slave (
        input  cmd_valid_i, cmd_on_i, pwr_ack_i, cluster_busy_i,
        output cmd_ready_o, cluster_pow_o, cluster_byp_o, cluster_rstn_o,
               cluster_fetch_enable_o, done_o, err_o, state_o, irq_o
    );
`else
    modport master (
        output cmd_valid_i, cmd_on_i, pwr_ack_i, cluster_busy_i,
        input  cmd_ready_o, cluster_pow_o, cluster_byp_o, cluster_rstn_o,
               cluster_fetch_enable_o, done_o, err_o, state_o
    );
    modport slave (
        input  cmd_valid_i, cmd_on_i, pwr_ack_i, cluster_busy_i,
        output cmd_ready_o, cluster_pow_o, cluster_byp_o, cluster_rstn_o,
               cluster_fetch_enable_o, done_o, err_o, state_o
    );
`endif
endinterface

// File: rtl/cluster_pwr_seq_timer.sv
// Loadable down counter with zero flag, saturating at 0.
// Latency: load takes effect on the next edge; zero is combinational from the count.
// Backpressure: none.
module cluster_pwr_seq_timer #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_val,
    output logic                 zero
);

    logic [CNT_WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CNT_WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/cluster_pwr_seq.sv
// Cluster power sequencer: pow -> byp release -> rstn release -> fetch, reverse on power-down; optional irq_o via CLUSTER_PWR_SEQ_IRQ_EN.
// Latency: accepted command changes state/outputs on the next cycle; done_o pulses on the cycle the sequence completes.
// Backpressure: cmd_ready_o only in OFF/ON/ERR; commands arriving in transient states are not accepted or queued.
module cluster_pwr_seq
    import cluster_pwr_seq_pkg::*;
#(
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
    parameter int ISO_CYCLES  = DEF_ISO_CYCLES,
    parameter int RST_CYCLES  = DEF_RST_CYCLES,
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
    input  logic              HCLK,
    input  logic              HRESET,
    cluster_pwr_seq_if.slave  pwr
);

    // Timer is loaded with N-1 so that zero marks the last cycle of an N-cycle window.
    localparam logic [CNT_WIDTH-1:0] ACK_LD = (ACK_TIMEOUT == 0) ? '0 : CNT_WIDTH'(ACK_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] ISO_LD = CNT_WIDTH'(ISO_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] RST_LD = CNT_WIDTH'(RST_CYCLES - 1);

    state_t               state_q;
    state_t               state_d;
    logic                 cmd_ready;
    logic                 accept;
    logic                 ack_timeout;
    logic                 tmr_load;
    logic [CNT_WIDTH-1:0] tmr_val;
    logic                 tmr_zero;
    logic                 done_d;
    logic                 err_set;
    logic                 err_clr;
    pwr_out_t             out_q;
    logic                 done_q;
    logic                 err_q;

    assign cmd_ready   = (state_q == ST_OFF) || (state_q == ST_ON) || (state_q == ST_ERR);
    assign accept      = pwr.cmd_valid_i && cmd_ready;
    assign ack_timeout = (ACK_TIMEOUT != 0) && tmr_zero;

    cluster_pwr_seq_timer #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_timer (
        .clk      (HCLK),
        .rst      (HRESET),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= ST_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        err_set  = 1'b0;
        err_clr  = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;

        case (state_q)
            ST_OFF: begin
                if (accept) begin
                    if (pwr.cmd_on_i) state_d = ST_PWR_UP;
                    else              done_d  = 1'b1;
                end
            end
            // Ack is checked before timeout so an ack on the final cycle still wins.
            ST_PWR_UP: begin
                if (pwr.pwr_ack_i)     state_d = ST_ISO;
                else if (ack_timeout)  state_d = ST_ERR;
            end
            ST_ISO: begin
                if (tmr_zero) state_d = ST_RST;
            end
            ST_RST: begin
                if (tmr_zero) begin
                    state_d = ST_ON;
                    done_d  = 1'b1;
                end
            end
            ST_ON: begin
                if (accept) begin
                    if (!pwr.cmd_on_i) state_d = ST_DRAIN;
                    else               done_d  = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!pwr.cluster_busy_i) state_d = ST_PWR_DN;
                else if (ack_timeout)    state_d = ST_ERR;
            end
            ST_PWR_DN: begin
                if (!pwr.pwr_ack_i) begin
                    state_d = ST_OFF;
                    done_d  = 1'b1;
                end else if (ack_timeout) begin
                    state_d = ST_ERR;
                end
            end
            ST_ERR: begin
                if (accept) begin
                    if (!pwr.cmd_on_i) state_d = ST_PWR_DN;
                    else               done_d  = 1'b1;
                end
            end
            default: state_d = ST_OFF;
        endcase

        if ((state_d == ST_ERR) && (state_q != ST_ERR)) begin
            done_d  = 1'b1;
            err_set = 1'b1;
        end

        // A power-up request while in ERR is dropped and must not hide the fault.
        err_clr = accept && !((state_q == ST_ERR) && pwr.cmd_on_i);

        if (state_d != state_q) begin
            tmr_load = 1'b1;
            case (state_d)
                ST_PWR_UP, ST_DRAIN, ST_PWR_DN: tmr_val = ACK_LD;
                ST_ISO:                         tmr_val = ISO_LD;
                ST_RST:                         tmr_val = RST_LD;
                default:                        tmr_val = '0;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            out_q  <= OUT_OFF;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            out_q  <= state_outputs(state_d, out_q.pow);
            done_q <= done_d;
            if (err_set) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

`ifdef CLUSTER_PWR_SEQ_IRQ_EN
    logic chg_q;
    logic irq_q;

    // No-op and dropped commands complete without a state change, so they raise no interrupt.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            chg_q <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            chg_q <= done_d && (state_d != state_q);
            irq_q <= chg_q;
        end
    end

    assign pwr.irq_o = irq_q;
`endif

    assign pwr.cmd_ready_o            = cmd_ready;
    assign pwr.cluster_pow_o          = out_q.pow;
    assign pwr.cluster_byp_o          = out_q.byp;
    assign pwr.cluster_rstn_o         = out_q.rstn;
    assign pwr.cluster_fetch_enable_o = out_q.fetch;
    assign pwr.done_o                 = done_q;
    assign pwr.err_o                  = err_q;
    assign pwr.state_o                = state_q;

endmodule

// File: tb/tb_cluster_pwr_seq.sv
// Bench for cluster_pwr_seq: directed and randomized command sequences against a timeline model.
module tb_cluster_pwr_seq;

    localparam int TO  = 16;
    localparam int ISO = 4;
    localparam int RST = 8;
`ifdef CLUSTER_PWR_SEQ_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic HCLK = 1'b0;
    logic HRESET;
    int   total = 0;
    int   bad   = 0;
    int   cur;
    bit   pe;

    cluster_pwr_seq_if pwr();

    cluster_pwr_seq #(
        .ACK_TIMEOUT (TO),
        .ISO_CYCLES  (ISO),
        .RST_CYCLES  (RST),
        .CNT_WIDTH   (16)
    ) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .pwr    (pwr)
    );

    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [10:0] o, input logic [10:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    // {state, pow, byp, rstn, fetch, done, err, ready, irq}
    function automatic logic [10:0] obs();
        logic irq;
        irq = 1'b0;
`ifdef CLUSTER_PWR_SEQ_IRQ_EN
        irq = pwr.irq_o;
`endif
        return {pwr.state_o, pwr.cluster_pow_o, pwr.cluster_byp_o, pwr.cluster_rstn_o,
                pwr.cluster_fetch_enable_o, pwr.done_o, pwr.err_o, pwr.cmd_ready_o, irq};
    endfunction

    function automatic logic [10:0] mk(int st, bit p, bit y, bit r, bit f, bit d, bit e, bit i);
        bit rdy;
        rdy = (st == 0) || (st == 4) || (st == 7);
        return {st[2:0], p, y, r, f, d, e, rdy, i & IRQ_ON};
    endfunction

    // Output levels each state must present, straight from the sequencing table.
    function automatic logic [10:0] ex(int st, bit pow_err, bit d, bit e, bit i);
        case (st)
            0:       return mk(0, 0, 1, 0, 0, d, e, i);
            1:       return mk(1, 1, 1, 0, 0, d, e, i);
            2:       return mk(2, 1, 0, 0, 0, d, e, i);
            3:       return mk(3, 1, 0, 1, 0, d, e, i);
            4:       return mk(4, 1, 0, 1, 1, d, e, i);
            5:       return mk(5, 1, 0, 1, 0, d, e, i);
            6:       return mk(6, 0, 1, 0, 0, d, e, i);
            default: return mk(7, pow_err, 1, 0, 0, d, e, i);
        endcase
    endfunction

    // Random commands while the sequencer is busy; they must be ignored.
    task automatic drive_cmd(input int st);
        if (st == 0 || st == 4 || st == 7) begin
            pwr.cmd_valid_i = 1'b0;
        end else begin
            pwr.cmd_valid_i = 1'($urandom_range(0, 1));
            pwr.cmd_on_i    = 1'($urandom_range(0, 1));
        end
    endtask

    // Power-up from OFF; the switch acks in cycle a after the accept cycle's successor.
    task automatic up(input int a);
        int s1, s2, s3, last, st;
        bit ok;
        ok   = (a <= TO - 1);
        s1   = a + 2;
        s2   = s1 + ISO;
        s3   = s2 + RST;
        last = ok ? s3 : TO + 1;
        pwr.pwr_ack_i   = 1'b0;
        pwr.cmd_valid_i = 1'b1;
        pwr.cmd_on_i    = 1'b1;
        tick();
        for (int k = 1; k <= last + 1; k++) begin
            if (!ok) st = (k <= TO) ? 1 : 7;
            else     st = (k < s1) ? 1 : (k < s2) ? 2 : (k < s3) ? 3 : 4;
            chk($sformatf("up a=%0d k=%0d", a, k), obs(),
                ex(st, 1'b1, k == last, !ok && k >= last, k == last + 1));
            pwr.pwr_ack_i = (k >= a + 1);
            drive_cmd(st);
            tick();
        end
        cur = ok ? 4 : 7;
        pe  = 1'b1;
    endtask

    // Power-down from ON (busy for b cycles) or from ERR; ack drops c cycles into PWR_DN.
    task automatic dn(input bit from_err, input int b, input int c);
        int d1, last, st;
        bit drain_ok, dn_ok, end_err, pe_end;
        if (from_err) begin
            drain_ok = 1'b1;
            d1       = 1;
        end else begin
            drain_ok = (b + 1 <= TO);
            d1       = b + 2;
        end
        dn_ok = (c + 1 <= TO);
        if (!drain_ok) begin
            last = TO + 1; end_err = 1'b1; pe_end = 1'b1;
        end else if (!dn_ok) begin
            last = d1 + TO; end_err = 1'b1; pe_end = 1'b0;
        end else begin
            last = d1 + c + 1; end_err = 1'b0; pe_end = 1'b0;
        end
        pwr.cluster_busy_i = (b > 0);
        pwr.cmd_valid_i    = 1'b1;
        pwr.cmd_on_i       = 1'b0;
        tick();
        for (int k = 1; k <= last + 1; k++) begin
            if (k >= last)              st = end_err ? 7 : 0;
            else if (!from_err && k < d1) st = 5;
            else                          st = 6;
            chk($sformatf("dn e=%0d b=%0d c=%0d k=%0d", from_err, b, c, k), obs(),
                ex(st, pe_end, k == last, end_err && k >= last, k == last + 1));
            pwr.cluster_busy_i = (k <= b);
            pwr.pwr_ack_i      = drain_ok ? (k < d1 + c) : 1'b1;
            drive_cmd(st);
            tick();
        end
        cur = end_err ? 7 : 0;
        pe  = pe_end;
    endtask

    // Command that leaves the state alone: done next cycle, nothing else moves.
    task automatic noop(input bit on);
        bit e;
        e = (cur == 7);
        pwr.cmd_valid_i = 1'b1;
        pwr.cmd_on_i    = on;
        tick();
        pwr.cmd_valid_i = 1'b0;
        chk($sformatf("noop st=%0d k=1", cur), obs(), ex(cur, pe, 1'b1, e, 1'b0));
        tick();
        chk($sformatf("noop st=%0d k=2", cur), obs(), ex(cur, pe, 1'b0, e, 1'b0));
    endtask

    initial begin
        HRESET             = 1'b1;
        pwr.cmd_valid_i    = 1'b0;
        pwr.cmd_on_i       = 1'b0;
        pwr.pwr_ack_i      = 1'b0;
        pwr.cluster_busy_i = 1'b0;
        cur                = 0;
        pe                 = 1'b0;
        tick();
        tick();
        chk("reset", obs(), ex(0, 1'b0, 1'b0, 1'b0, 1'b0));
        HRESET = 1'b0;
        tick();
        chk("idle after reset", obs(), ex(0, 1'b0, 1'b0, 1'b0, 1'b0));

        up(3);
        noop(1'b1);
        dn(1'b0, 10, 2);
        noop(1'b0);
        up(20);
        noop(1'b1);
        dn(1'b1, 0, 1);
        up(TO - 1);
        dn(1'b0, TO - 1, TO - 1);
        up(0);
        dn(1'b0, 0, 0);

        for (int n = 0; n < 30; n++) begin
            int r;
            r = $urandom_range(0, 9);
            case (cur)
                0: if (r < 2) noop(1'b0); else up($urandom_range(0, 20));
                4: if (r < 2) noop(1'b1); else dn(1'b0, $urandom_range(0, 20), $urandom_range(0, 20));
                default: if (r < 3) noop(1'b1); else dn(1'b1, 0, $urandom_range(0, 20));
            endcase
        end

        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        pwr.cmd_valid_i = 1'b0;
        pwr.pwr_ack_i   = 1'b0;
        chk("reset after random", obs(), ex(0, 1'b0, 1'b0, 1'b0, 1'b0));
        pwr.cmd_valid_i = 1'b1;
        pwr.cmd_on_i    = 1'b1;
        tick();
        pwr.cmd_valid_i = 1'b0;
        pwr.pwr_ack_i   = 1'b1;
        tick();
        chk("iso entered", obs(), ex(2, 1'b0, 1'b0, 1'b0, 1'b0));
        HRESET = 1'b1;
        tick();
        chk("reset in iso", obs(), ex(0, 1'b0, 1'b0, 1'b0, 1'b0));
        HRESET        = 1'b0;
        pwr.pwr_ack_i = 1'b0;
        tick();
        chk("idle after iso reset", obs(), ex(0, 1'b0, 1'b0, 1'b0, 1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
